// File: rtl/pwm_fade_pkg.sv
// Shared encodings, limits and gamma table for the LED PWM fade controller.
package pwm_fade_pkg;

  localparam int LVL_MIN = 1;
  localparam int LVL_MAX = 15;
  localparam int PERIOD  = 16;

  localparam logic [1:0] MODE_SET     = 2'b00;
  localparam logic [1:0] MODE_FADE    = 2'b01;
  localparam logic [1:0] MODE_BREATHE = 2'b10;
  localparam logic [1:0] MODE_RSVD    = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FADE  = 2'b01,
    BR_UP = 2'b10,
    BR_DN = 2'b11
  } state_t;

  // Index 0 is never addressed (level is never 0); it mirrors index 1.
  localparam logic [15:0][3:0] GAMMA_LUT = {
    4'd15, 4'd12, 4'd10, 4'd9, 4'd7, 4'd6, 4'd5, 4'd4,
    4'd3,  4'd2,  4'd2,  4'd1, 4'd1, 4'd1, 4'd1, 4'd1
  };

  function automatic logic [3:0] clamp_lvl(input logic [3:0] v);
    logic [4:0] vx;
    logic [3:0] r;
    vx = {1'b0, v};
    r  = v;
    if (v == 4'd0) begin
      r = 4'(LVL_MIN);
    end else if (vx > 5'(LVL_MAX)) begin
      r = 4'(LVL_MAX);
    end
    return r;
  endfunction

endpackage

// File: rtl/pwm_fade_prescaler.sv
// Step-rate down-counter: tick when the count is zero, then reload from the latched rate.
// A load always wins over a coincident tick, which is suppressed.
module pwm_fade_prescaler #(
  parameter int RATE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [RATE_W-1:0] load_val,
  output logic              tick
);

  logic [RATE_W-1:0] cnt_q, cnt_d;
  logic [RATE_W-1:0] rate_q, rate_d;

  always_comb begin
    cnt_d  = cnt_q;
    rate_d = rate_q;
    if (load) begin
      cnt_d  = load_val;
      rate_d = load_val;
    end else if (cnt_q == '0) begin
      cnt_d = rate_q;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign tick = (cnt_q == '0) && !load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      rate_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      rate_q <= rate_d;
    end
  end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// LED brightness controller (set / linear fade / breathe) feeding a PWM generator's rise/fall counts.
// New counts commit only on a rising edge of pwm_sync; PWM_FADE_GAMMA_EN selects gamma-mapped rise.
module pwm_fade_ctrl
  import pwm_fade_pkg::*;
#(
  parameter int RATE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_mode,
  input  logic [3:0]        cmd_level,
  input  logic [RATE_W-1:0] cmd_rate,
  input  logic              pwm_sync,
  output logic [3:0]        rise,
  output logic [3:0]        fall,
  output logic              busy,
  output logic              fade_done
);

  state_t     state_q, state_d;
  logic [3:0] level_q, level_d;
  logic [3:0] target_q, target_d;
  logic [3:0] floor_q, floor_d;
  logic [3:0] rise_q, rise_d;
  logic [3:0] fall_q, fall_d;
  logic       pwm_sync_q;

  logic       accept;
  logic       tick;
  logic [3:0] lvl_c;
  logic [3:0] shadow_rise;
  logic [4:0] shadow_fall;
  logic       commit;

  assign cmd_ready = (state_q != FADE);
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state_q != IDLE);
  assign lvl_c     = clamp_lvl(cmd_level);

  pwm_fade_prescaler #(
    .RATE_W (RATE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (reset),
    .load     (accept),
    .load_val (cmd_rate),
    .tick     (tick)
  );

  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    target_d  = target_q;
    floor_d   = floor_q;
    fade_done = 1'b0;
    if (accept) begin
      case (cmd_mode)
        MODE_SET: begin
          level_d = lvl_c;
          state_d = IDLE;
        end
        MODE_FADE: begin
          target_d = lvl_c;
          state_d  = FADE;
        end
        MODE_BREATHE: begin
          floor_d = lvl_c;
          state_d = BR_UP;
        end
        MODE_RSVD: ;
        default: ;
      endcase
    end else begin
      case (state_q)
        FADE: begin
          if (level_q == target_q) begin
            fade_done = 1'b1;
            state_d   = IDLE;
          end else if (tick) begin
            level_d = (level_q < target_q) ? level_q + 4'd1 : level_q - 4'd1;
          end
        end
        // Turnaround happens on the tick that would overshoot, so each end is shown for one tick.
        BR_UP: begin
          if (tick) begin
            if (level_q < 4'(LVL_MAX)) begin
              level_d = level_q + 4'd1;
            end else if (level_q > floor_q) begin
              level_d = level_q - 4'd1;
              state_d = BR_DN;
            end
          end
        end
        BR_DN: begin
          if (tick) begin
            if (level_q > floor_q) begin
              level_d = level_q - 4'd1;
            end else if (level_q < 4'(LVL_MAX)) begin
              level_d = level_q + 4'd1;
              state_d = BR_UP;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PWM_FADE_GAMMA_EN
  assign shadow_rise = GAMMA_LUT[level_q];
`else
  assign shadow_rise = level_q;
`endif

  assign shadow_fall = 5'(PERIOD) - {1'b0, shadow_rise};
  assign commit      = pwm_sync && !pwm_sync_q;

  always_comb begin
    rise_d = rise_q;
    fall_d = fall_q;
    if (commit) begin
      rise_d = shadow_rise;
      fall_d = shadow_fall[3:0];
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      level_q    <= 4'(LVL_MIN);
      target_q   <= 4'(LVL_MIN);
      floor_q    <= 4'(LVL_MIN);
      rise_q     <= 4'd1;
      fall_q     <= 4'd15;
      pwm_sync_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      target_q   <= target_d;
      floor_q    <= floor_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      pwm_sync_q <= pwm_sync;
    end
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl: set, fade, breathe, abort, clamp, tick collision, reset, commit.
module tb_pwm_fade_ctrl;
  import pwm_fade_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mode;
  logic [3:0] cmd_level;
  logic [7:0] cmd_rate;
  logic       pwm_sync;
  logic [3:0] rise;
  logic [3:0] fall;
  logic       busy;
  logic       fade_done;

  logic       pwm_auto;
  logic       sync_man;
  logic [3:0] pcnt;

  int n_chk;
  int n_fail;
  int br_exp[6] = '{14, 15, 14, 13, 14, 15};

  pwm_fade_ctrl #(.RATE_W(8)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_level (cmd_level),
    .cmd_rate  (cmd_rate),
    .pwm_sync  (pwm_sync),
    .rise      (rise),
    .fall      (fall),
    .busy      (busy),
    .fade_done (fade_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Simple PWM generator model: high for the first `rise` counts of a 16-count period.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pcnt <= 4'd0;
    else        pcnt <= pcnt + 4'd1;
  end

  assign pwm_sync = pwm_auto ? (pcnt < rise) : sync_man;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] m, input logic [3:0] l, input logic [7:0] r);
    cmd_mode  = m;
    cmd_level = l;
    cmd_rate  = r;
    cmd_valid = 1'b1;
    cyc(1);
    cmd_valid = 1'b0;
  endtask

  task automatic pwm_edge();
    sync_man = 1'b0;
    cyc(1);
    sync_man = 1'b1;
    cyc(1);
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    cmd_valid = 1'b0;
    cmd_mode  = 2'd0;
    cmd_level = 4'd0;
    cmd_rate  = 8'd0;
    pwm_auto  = 1'b1;
    sync_man  = 1'b1;
    rst_n     = 1'b1;
    #2 rst_n  = 1'b0;
    cyc(2);
    chk("rst_rise", rise, 1);
    chk("rst_fall", fall, 15);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_done", fade_done, 0);
    chk("rst_level", dut.level_q, 1);

    rst_n = 1'b1;
    cyc(40);
    chk("idle_rise", rise, 1);
    chk("idle_fall", fall, 15);
    chk("idle_busy", busy, 0);
    pwm_auto = 1'b0;
    sync_man = 1'b1;
    cyc(2);

    // SET mid-period: counts wait for the next pwm_sync rising edge
    send(MODE_SET, 4'd10, 8'd0);
    chk("set_level", dut.level_q, 10);
    chk("set_rise_hold", rise, 1);
    chk("set_fall_hold", fall, 15);
    chk("set_done", fade_done, 0);
    cyc(3);
    chk("set_rise_hold2", rise, 1);
    sync_man = 1'b0;
    cyc(1);
    chk("set_rise_low", rise, 1);
    sync_man = 1'b1;
    cyc(1);
    chk("set_rise_commit", rise, 10);
    chk("set_fall_commit", fall, 6);

    // FADE 10 -> 4 at rate 3, with a SET 8 held pending throughout
    cmd_mode  = MODE_FADE;
    cmd_level = 4'd4;
    cmd_rate  = 8'd3;
    cmd_valid = 1'b1;
    cyc(1);
    cmd_mode  = MODE_SET;
    cmd_level = 4'd8;
    cmd_rate  = 8'd0;
    chk("fade_busy", busy, 1);
    chk("fade_ready", cmd_ready, 0);
    for (int k = 1; k <= 24; k++) begin
      cyc(1);
      if (k % 4 == 0) chk("fade_level", dut.level_q, 10 - k / 4);
      chk("fade_ready_low", cmd_ready, 0);
      chk("fade_done_pulse", fade_done, (k == 24) ? 1 : 0);
    end
    cyc(1);
    chk("fade_end_done", fade_done, 0);
    chk("fade_end_ready", cmd_ready, 1);
    chk("fade_end_level", dut.level_q, 4);
    chk("fade_end_busy", busy, 0);
    cyc(1);
    chk("held_cmd_level", dut.level_q, 8);
    cmd_valid = 1'b0;

    // BREATHE floor 13, rate 0, then abort with SET 2
    send(MODE_SET, 4'd13, 8'd0);
    chk("br_pre_level", dut.level_q, 13);
    send(MODE_BREATHE, 4'd13, 8'd0);
    chk("br_busy", busy, 1);
    chk("br_entry_level", dut.level_q, 13);
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      chk("br_level", dut.level_q, br_exp[i]);
    end
    send(MODE_SET, 4'd2, 8'd0);
    chk("abort_level", dut.level_q, 2);
    chk("abort_busy", busy, 0);

    // FADE with cmd_level 0 clamps the target to 1
    send(MODE_FADE, 4'd0, 8'd0);
    chk("clamp_busy", busy, 1);
    chk("clamp_level0", dut.level_q, 2);
    cyc(1);
    chk("clamp_level1", dut.level_q, 1);
    chk("clamp_done", fade_done, 1);
    cyc(1);
    chk("clamp_done_clr", fade_done, 0);
    chk("clamp_busy_clr", busy, 0);
    chk("clamp_level_hold", dut.level_q, 1);

    // FADE to the current level completes immediately
    send(MODE_FADE, 4'd1, 8'd0);
    chk("eq_done", fade_done, 1);
    chk("eq_level", dut.level_q, 1);
    cyc(1);
    chk("eq_done_clr", fade_done, 0);
    chk("eq_ready", cmd_ready, 1);

    // Reserved mode changes nothing
    send(MODE_RSVD, 4'd9, 8'd5);
    chk("rsvd_level", dut.level_q, 1);
    chk("rsvd_busy", busy, 0);
    chk("rsvd_ready", cmd_ready, 1);

    // Command colliding with a tick: tick dropped, prescaler reloaded with the new rate
    send(MODE_SET, 4'd5, 8'd0);
    chk("coll_pre", dut.level_q, 5);
    send(MODE_BREATHE, 4'd1, 8'd0);
    chk("coll_entry", dut.level_q, 5);
    cyc(1);
    chk("coll_step", dut.level_q, 6);
    send(MODE_BREATHE, 4'd1, 8'd2);
    chk("coll_discard", dut.level_q, 6);
    cyc(1);
    chk("coll_wait1", dut.level_q, 6);
    cyc(1);
    chk("coll_wait2", dut.level_q, 6);
    cyc(1);
    chk("coll_tick", dut.level_q, 7);

    // Reset in the middle of a fade at level 7
    send(MODE_SET, 4'd7, 8'd0);
    pwm_edge();
    chk("pre_rst_rise", rise, 7);
    chk("pre_rst_fall", fall, 9);
    send(MODE_FADE, 4'd2, 8'd3);
    cyc(1);
    chk("mid_fade_busy", busy, 1);
    chk("mid_fade_level", dut.level_q, 7);
    rst_n = 1'b0;
    #1;
    chk("arst_level", dut.level_q, 1);
    chk("arst_rise", rise, 1);
    chk("arst_fall", fall, 15);
    chk("arst_busy", busy, 0);
    chk("arst_ready", cmd_ready, 1);
    chk("arst_done", fade_done, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("arst_done_hold", fade_done, 0);
    end
    rst_n = 1'b1;
    cyc(2);

    // Commit at level 12 (gamma-mapped when enabled)
    send(MODE_SET, 4'd12, 8'd0);
    pwm_edge();
`ifdef PWM_FADE_GAMMA_EN
    chk("l12_rise", rise, 9);
    chk("l12_fall", fall, 7);
`else
    chk("l12_rise", rise, 12);
    chk("l12_fall", fall, 4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_fade_ctrl.md
Name: pwm_fade_ctrl

Overview:
- Upstream control stage for the front-panel LED PWM generator.
- Owns a brightness level and drives the generator's 4-bit rise (on-count) and fall (off-count) inputs, keeping rise+fall = 16.
- Supports immediate set, timed linear fade and continuous breathe.
- New counts are committed only at the start of a PWM period, detected from the generator's output, so periods are never truncated.

Parameters:
- LVL_MAX, 15, highest legal level. Levels are clamped to 1..LVL_MAX.
- PERIOD, 16, total counts per PWM period. fall = PERIOD - rise.
- RATE_W, 8, width of the step-rate prescaler.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command strobe
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_mode  in  2  00 SET, 01 FADE, 10 BREATHE, 11 reserved
- cmd_level  in  4  target level (FADE, SET) or floor level (BREATHE)
- cmd_rate  in  RATE_W  cycles between steps = cmd_rate+1
- pwm_sync  in  1  PWM generator output, fed back
- rise  out  4  on-count to PWM generator
- fall  out  4  off-count to PWM generator
- busy  out  1  high in FADE or BREATHE states
- fade_done  out  1  one-cycle pulse when a FADE reaches its target

Behaviour:
- Reset values:
  - level=1, target=1, state IDLE, prescaler=0, rate=0.
  - rise=1, fall=15, busy=0, fade_done=0, cmd_ready=1.
  - pwm_sync_q=1, matching the generator's reset-high output so no false edge is seen.
- Clamp: a cmd_level of 0 is treated as 1. Values above LVL_MAX are clamped to LVL_MAX.
- cmd_ready = 0 only in FADE. IDLE and BREATHE accept commands; a new command aborts BREATHE.
- On accept:
  - cmd_rate is latched and the prescaler is loaded with cmd_rate.
  - A command in the same cycle as a tick wins; that tick is discarded.
- Tick: the prescaler decrements each cycle; tick=1 when it reaches 0, then it reloads. With rate 0, every cycle is a tick.
- States:
  - IDLE: level holds.
  - SET (mode 00): level=clamped cmd_level on the next edge, stays IDLE, fade_done is not pulsed.
  - FADE (mode 01): target=clamped cmd_level. Each tick moves level one step toward target. The cycle level==target is evaluated, fade_done pulses and state returns to IDLE. If level already equals target at accept, fade_done pulses on the next cycle with no ticks.
  - BREATHE_UP / BREATHE_DOWN (mode 10): floor=clamped cmd_level. Entry is BREATHE_UP. On each tick in UP, level+1 until LVL_MAX, then switch to DOWN. On each tick in DOWN, level-1 until floor, then switch to UP. There is no dwell beyond one tick at each end. If floor==LVL_MAX, level holds at LVL_MAX.
  - Mode 11: accepted, no state or level change.
- Commit:
  - shadow_rise = level (or its mapped value, see Optional Feature); shadow_fall = PERIOD - shadow_rise.
  - rise/fall load from the shadow at the clock edge where pwm_sync==1 && pwm_sync_q==0 (rising edge of the PWM output), so they become visible one cycle after the edge.
  - Between commits, rise/fall are stable.
  - Multiple level changes within one period: only the value present at the commit edge is applied.
- Width rules: level is 4-bit unsigned and never 0. fall = PERIOD - rise is computed in 5 bits and truncated to 4. The range 1..15 is guaranteed.
- Reset mid-fade or mid-breathe: all state returns to reset values immediately (asynchronous), and there is no fade_done.

Optional Feature:
- Macro: PWM_FADE_GAMMA_EN.
- Defined: shadow_rise = GAMMA_LUT[level], with LUT(1..15) = 1,1,1,1,2,2,3,4,5,6,7,9,10,12,15. The state machine and level sequencing are unchanged.
- Undefined: shadow_rise = level, linear.

Decomposition:
- Package pwm_fade_pkg holds:
  - mode encodings MODE_SET / FADE / BREATHE / RSVD;
  - state enum IDLE, FADE, BR_UP, BR_DN;
  - LVL_MIN=1, LVL_MAX, PERIOD;
  - GAMMA_LUT constant.
- One sub-module: pwm_fade_prescaler, containing the RATE_W down-counter with load and tick outputs.
- The state machine, clamp and commit logic stay in the top module.

Test Plan:
- Reset, pwm_sync toggling from a PWM model -> rise=1, fall=15, busy=0, cmd_ready=1; no commit on the first cycle after reset deassertion.
- SET level 10 mid-period -> rise/fall stay 1/15 until the next pwm_sync rising edge, then 10/6 one cycle later; fade_done stays 0.
- FADE 10->4, rate 3 -> level steps every 4 cycles, giving 9,8,7,6,5,4. Timing:
  - cmd_ready=0 throughout the fade;
  - fade_done pulses once, when level reaches 4;
  - cmd_ready=1 the following cycle;
  - a cmd_valid held during the fade is accepted only after it ends.
- BREATHE floor 13, rate 0 -> level 14,15,14,13,14,... each cycle. A SET 2 issued during the ramp aborts it, with level=2 and busy=0 next cycle.
- Edge cases: cmd_level=0 in FADE, mode 11, and a command coinciding with a tick -> FADE target is 1; mode 11 causes no change; the coincident tick is discarded and the prescaler reloaded.
- Reset asserted mid-FADE at level 7 -> immediate reset values, no fade_done. With PWM_FADE_GAMMA_EN, a commit at level 12 gives rise/fall=9/7.
